// File: rtl/pla_opa_pkg.sv
// Shared constants, FSM state type and beat-count helpers for the opa PLA output serializer.
package pla_opa_pkg;

  localparam int PLA_OPA_NOUT = 69;
  localparam int PLA_OPA_NZ   = 61;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  function automatic int nbeats(input int beat_w);
    return (PLA_OPA_NZ + beat_w - 1) / beat_w;
  endfunction

  // Keeps beat-index ports at least one bit wide when a word fits in one beat.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pla_opa_beat_select.sv
// Priority finder: lowest nonzero beat above idx_i (or at idx_i when incl_i=1).
// last_o=1 means no such beat exists, i.e. the beat at idx_i is the final one to emit.
module pla_opa_beat_select #(
  parameter int BEAT_W = 8,
  parameter int NBEATS = 8,
  parameter int IDX_W  = 3
) (
  input  logic [NBEATS*BEAT_W-1:0] word_i,
  input  logic [IDX_W-1:0]         idx_i,
  input  logic                     incl_i,
  output logic [IDX_W-1:0]         next_idx_o,
  output logic                     last_o
);

  logic [NBEATS-1:0] nz;

  for (genvar gi = 0; gi < NBEATS; gi++) begin : g_nz
    assign nz[gi] = |word_i[gi*BEAT_W +: BEAT_W];
  end

  // Descending scan so the lowest qualifying beat is the one left standing.
  always_comb begin
    next_idx_o = '0;
    last_o     = 1'b1;
    for (int b = NBEATS - 1; b >= 0; b--) begin
      if (nz[b] && ((b > int'(idx_i)) || (incl_i && (b == int'(idx_i))))) begin
        next_idx_o = IDX_W'(b);
        last_o     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pla_opa_out_serializer.sv
// Captures a 69-bit opa PLA word, drops z61..z68 and streams the rest as BEAT_W-bit beats.
// Optional zero-beat skipping is enabled by defining PLA_OPA_SER_SKIP_EN.
module pla_opa_out_serializer
  import pla_opa_pkg::*;
#(
  parameter int  BEAT_W = 8,
  parameter int  CNT_W  = 16,
  localparam int NBEATS = nbeats(BEAT_W),
  localparam int IDX_W  = idx_width(NBEATS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PLA_OPA_NOUT-1:0] in_z,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BEAT_W-1:0]       out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic [CNT_W-1:0]        word_cnt
);

  localparam int              PAD_W    = NBEATS * BEAT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  ser_state_t                        state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [PLA_OPA_NZ-1:0]             shadow_q, shadow_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [PAD_W-1:0]                  shadow_pad;
  logic [BEAT_W-1:0]                 beat_arr [NBEATS];
  logic [IDX_W-1:0]                  first_idx;
  logic [IDX_W-1:0]                  next_idx;
  logic                              cur_last;
  logic                              xfer;
  logic                              capture;
  logic [PLA_OPA_NOUT-PLA_OPA_NZ-1:0] unused_z_hi;

  assign unused_z_hi = in_z[PLA_OPA_NOUT-1:PLA_OPA_NZ];
  assign shadow_pad  = PAD_W'(shadow_q);

  for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat
    assign beat_arr[gi] = shadow_pad[gi*BEAT_W +: BEAT_W];
  end

`ifdef PLA_OPA_SER_SKIP_EN
  logic [PAD_W-1:0] in_pad;
  logic [IDX_W-1:0] first_raw;
  logic             first_none;
  logic             next_none;

  assign in_pad = PAD_W'(in_z[PLA_OPA_NZ-1:0]);

  pla_opa_beat_select #(
    .BEAT_W (BEAT_W),
    .NBEATS (NBEATS),
    .IDX_W  (IDX_W)
  ) u_first (
    .word_i     (in_pad),
    .idx_i      ('0),
    .incl_i     (1'b1),
    .next_idx_o (first_raw),
    .last_o     (first_none)
  );

  pla_opa_beat_select #(
    .BEAT_W (BEAT_W),
    .NBEATS (NBEATS),
    .IDX_W  (IDX_W)
  ) u_next (
    .word_i     (shadow_pad),
    .idx_i      (idx_q),
    .incl_i     (1'b0),
    .next_idx_o (next_idx),
    .last_o     (next_none)
  );

  // An all-zero word still needs one beat so the sink sees out_last.
  assign first_idx = first_none ? LAST_IDX : first_raw;
  assign cur_last  = next_none;
`else
  assign first_idx = '0;
  assign next_idx  = idx_q + IDX_W'(1);
  assign cur_last  = (idx_q == LAST_IDX);
`endif

  assign out_valid = (state_q == SEND);
  assign out_idx   = idx_q;
  assign out_data  = out_valid ? beat_arr[idx_q] : '0;
  assign out_last  = out_valid & cur_last;
  assign xfer      = out_valid & out_ready;
  assign in_ready  = rst_n & (~out_valid | (xfer & out_last));
  assign capture   = in_valid & in_ready;
  assign word_cnt  = cnt_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          shadow_d = in_z[PLA_OPA_NZ-1:0];
          idx_d    = first_idx;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (cur_last) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (capture) begin
              shadow_d = in_z[PLA_OPA_NZ-1:0];
              idx_d    = first_idx;
            end else begin
              state_d = IDLE;
              idx_d   = '0;
            end
          end else begin
            idx_d = next_idx;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
